// File: rtl/img_absdiff_if.sv
// Pixel-in / result-out stream bundle for img_absdiff; slave is the block's view, master the driver's.
// out_sum (and the N_PIX parameter sizing it) exists only when IMG_ABSDIFF_SUM_EN is defined.
interface img_absdiff_if #(
  parameter int PIX_W = 4
`ifdef IMG_ABSDIFF_SUM_EN
  , parameter int N_PIX = 9
`endif
);
`ifdef IMG_ABSDIFF_SUM_EN
  localparam int SUM_W = PIX_W + $clog2(N_PIX + 1);
  logic [SUM_W-1:0] out_sum;
`endif
  logic             in_valid;
  logic [PIX_W-1:0] in_image;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_diff;
  logic             out_last;

`ifdef IMG_ABSDIFF_SUM_EN
  modport slave  (input  in_valid, in_image, out_ready,
                  output in_ready, out_valid, out_diff, out_last, out_sum);
  modport master (output in_valid, in_image, out_ready,
                  input  in_ready, out_valid, out_diff, out_last, out_sum);
`else
  modport slave  (input  in_valid, in_image, out_ready,
                  output in_ready, out_valid, out_diff, out_last);
  modport master (output in_valid, in_image, out_ready,
                  input  in_ready, out_valid, out_diff, out_last);
`endif
endinterface

// File: rtl/img_absdiff.sv
// Loads image A then image B, computes R[i]=f(A[i],B[i]) per MODE while B streams in, then replays R.
// Optional IMG_ABSDIFF_SUM_EN adds out_sum, the frame total of R presented alongside out_last.
module img_absdiff #(
  parameter int PIX_W = 4,
  parameter int N_PIX = 9,
  parameter int MODE  = 0
) (
  input logic         clk,
  input logic         rst,
  img_absdiff_if.slave bus
);
  localparam int IDX_W = $clog2(N_PIX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);
  localparam logic [1:0] IDLE = 2'd0, LOAD_A = 2'd1, LOAD_B = 2'd2, OUTPUT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_diff_q, out_diff_d;
  logic             out_last_q, out_last_d;
  logic [PIX_W-1:0] a_mem [N_PIX];
  logic [PIX_W-1:0] r_mem [N_PIX];
  logic             in_fire, out_fire;
  logic [PIX_W-1:0] r_new;

  function automatic logic [PIX_W-1:0] calc(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    logic [PIX_W-1:0] res;
    if (MODE == 1)      res = (a >= b) ? a - b : b - a;
    else if (MODE == 2) res = (a >= b) ? a - b : '0;
    else                res = a - b;
    return res;
  endfunction

  assign in_fire  = bus.in_valid && (state_q != OUTPUT);
  assign out_fire = out_valid_q && bus.out_ready;
  assign idx_nxt  = idx_q + 1'b1;
  assign r_new    = calc(a_mem[idx_q], bus.in_image);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_diff_d  = out_diff_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: if (in_fire) begin
        state_d = LOAD_A;
        idx_d   = IDX_W'(1);
      end
      LOAD_A: if (in_fire) begin
        if (idx_q == LAST_IDX) begin
          state_d = LOAD_B;
          idx_d   = '0;
        end else begin
          idx_d = idx_nxt;
        end
      end
      LOAD_B: if (in_fire) begin
        if (idx_q == LAST_IDX) begin
          // R[0] was stored long ago, so the first result is ready the very next cycle
          state_d     = OUTPUT;
          idx_d       = '0;
          out_valid_d = 1'b1;
          out_diff_d  = r_mem[0];
          out_last_d  = 1'b0;
        end else begin
          idx_d = idx_nxt;
        end
      end
      default: if (out_fire) begin
        if (out_last_q) begin
          state_d     = IDLE;
          idx_d       = '0;
          out_valid_d = 1'b0;
          out_diff_d  = '0;
          out_last_d  = 1'b0;
        end else begin
          idx_d      = idx_nxt;
          out_diff_d = r_mem[idx_nxt];
          out_last_d = (idx_nxt == LAST_IDX);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_diff_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_diff_q  <= out_diff_d;
      out_last_q  <= out_last_d;
    end
  end

  // Pixel/result storage carries no reset; a new frame overwrites every entry before it is read
  always_ff @(posedge clk) begin
    if (!rst && in_fire) begin
      if (state_q == LOAD_B) r_mem[idx_q] <= r_new;
      else                   a_mem[idx_q] <= bus.in_image;
    end
  end

  assign bus.in_ready  = (state_q != OUTPUT);
  assign bus.out_valid = out_valid_q;
  assign bus.out_diff  = out_diff_q;
  assign bus.out_last  = out_last_q;

`ifdef IMG_ABSDIFF_SUM_EN
  localparam int SUM_W = PIX_W + $clog2(N_PIX + 1);
  logic [SUM_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (state_q == LOAD_B && in_fire)            acc_d = acc_q + SUM_W'(r_new);
    else if (out_fire && out_last_q)             acc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign bus.out_sum = out_last_q ? acc_q : '0;
`endif
endmodule

// File: tb/tb_img_absdiff.sv
// Drives one shared stream into three img_absdiff instances (MODE 0/1/2) and checks each against a frame-level model.
module tb_img_absdiff;
  localparam int PW = 4;
  localparam int NP = 9;

  logic clk;
  logic rst;
  logic in_valid;
  logic [PW-1:0] in_image;
  logic out_ready;
  bit   toggle_en;

  img_absdiff_if #(.PIX_W(PW)) if0 ();
  img_absdiff_if #(.PIX_W(PW)) if1 ();
  img_absdiff_if #(.PIX_W(PW)) if2 ();

  assign if0.in_valid = in_valid;  assign if0.in_image = in_image;  assign if0.out_ready = out_ready;
  assign if1.in_valid = in_valid;  assign if1.in_image = in_image;  assign if1.out_ready = out_ready;
  assign if2.in_valid = in_valid;  assign if2.in_image = in_image;  assign if2.out_ready = out_ready;

  img_absdiff #(.PIX_W(PW), .N_PIX(NP), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  img_absdiff #(.PIX_W(PW), .N_PIX(NP), .MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  img_absdiff #(.PIX_W(PW), .N_PIX(NP), .MODE(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic          rdy [3];
  logic          vld [3];
  logic [PW-1:0] dif [3];
  logic          lst [3];
  assign rdy[0] = if0.in_ready;  assign vld[0] = if0.out_valid;  assign dif[0] = if0.out_diff;  assign lst[0] = if0.out_last;
  assign rdy[1] = if1.in_ready;  assign vld[1] = if1.out_valid;  assign dif[1] = if1.out_diff;  assign lst[1] = if1.out_last;
  assign rdy[2] = if2.in_ready;  assign vld[2] = if2.out_valid;  assign dif[2] = if2.out_diff;  assign lst[2] = if2.out_last;
`ifdef IMG_ABSDIFF_SUM_EN
  logic [7:0] sm [3];
  assign sm[0] = if0.out_sum;  assign sm[1] = if1.out_sum;  assign sm[2] = if2.out_sum;
  int sum_at_last1;
`endif

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int m, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut_mode%0d actual=%0d required=%0d t=%0t", nm, m, act, exp, $time);
    end
  endtask

  function automatic int ref_res(input int mode, input int a, input int b);
    if (mode == 1) return (a >= b) ? a - b : b - a;
    if (mode == 2) return (a >= b) ? a - b : 0;
    return ((a - b) % 16 + 16) % 16;
  endfunction

  // Frame-level model: how many pixels taken this frame, how many results delivered
  int  m_acc, m_out;
  int  a_m [NP];
  int  b_m [NP];
  int  cyc, last_acc_cyc, first_vld_cyc;
  bit  chk_en, seen_vld;
  int  got0[$], got1[$], got2[$];
  int  last_pos0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_acc  = 0;
      m_out  = 0;
      chk_en = 1'b1;
    end else if (chk_en) begin
      if (m_acc < 2*NP) begin
        if (in_valid) begin
          if (m_acc < NP) a_m[m_acc] = int'(in_image);
          else            b_m[m_acc-NP] = int'(in_image);
          m_acc++;
          if (m_acc == 2*NP) last_acc_cyc = cyc;
        end
      end else if (out_ready) begin
        m_out++;
        if (m_out == NP) begin
          m_acc = 0;
          m_out = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 3; m++) begin
        bit ev;
        int ed;
        ev = (m_acc == 2*NP);
        ed = ev ? ref_res(m, a_m[m_out], b_m[m_out]) : 0;
        chk("in_ready", m, int'(rdy[m]), int'(m_acc < 2*NP));
        chk("out_valid", m, int'(vld[m]), int'(ev));
        chk("out_diff", m, int'(dif[m]), ed);
        chk("out_last", m, int'(lst[m]), int'(ev && m_out == NP-1));
`ifdef IMG_ABSDIFF_SUM_EN
        begin
          int es;
          es = 0;
          if (ev && m_out == NP-1)
            for (int i = 0; i < NP; i++) es += ref_res(m, a_m[i], b_m[i]);
          chk("out_sum", m, int'(sm[m]), es);
        end
`endif
        if (vld[m] && out_ready) begin
          if (m == 0) begin
            got0.push_back(int'(dif[0]));
            if (lst[0]) last_pos0 = got0.size();
          end else if (m == 1) begin
            got1.push_back(int'(dif[1]));
`ifdef IMG_ABSDIFF_SUM_EN
            if (lst[1]) sum_at_last1 = int'(sm[1]);
`endif
          end else begin
            got2.push_back(int'(dif[2]));
          end
        end
      end
      if (vld[0] && !seen_vld) begin
        seen_vld      = 1'b1;
        first_vld_cyc = cyc;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = toggle_en ? !out_ready : 1'b1;
    end
  end

  task automatic clear_got();
    got0.delete(); got1.delete(); got2.delete();
    seen_vld  = 1'b0;
    last_pos0 = 0;
  endtask

  task automatic drive_frame(input int a[NP], input int b[NP], input int npix, input bit gaps);
    for (int k = 0; k < npix; k++) begin
      bit ok;
      bit r;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_image = PW'((k < NP) ? a[k] : b[k-NP]);
      ok = 1'b0;
      for (int t = 0; t < 60 && !ok; t++) begin
        @(negedge clk); r = rdy[0];
        @(posedge clk); #1;
        ok = r;
      end
      if (!ok) chk("accept_timeout", 0, 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (got0.size() < NP && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int a[NP];
    int b[NP];
    int exp5[NP];
    rst = 1'b1; in_valid = 1'b0; in_image = '0; toggle_en = 1'b0;
    checks = 0; failures = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 0, int'(rdy[0]), 1);
    chk("reset_out_valid", 0, int'(vld[0]), 0);
    @(posedge clk); #1;

    // A all 3, B all 5, back-to-back, no stalls
    clear_got();
    foreach (a[i]) begin a[i] = 3; b[i] = 5; end
    drive_frame(a, b, 2*NP, 1'b0);
    wait_done();
    chk("f1_count", 0, got0.size(), NP);
    if (got0.size() == NP) for (int i = 0; i < NP; i++) chk("f1_wrap_E", 0, got0[i], 14);
    if (got1.size() > 0) chk("f1_abs", 1, got1[0], 2);
    if (got2.size() > 0) chk("f1_sat", 2, got2[0], 0);
    chk("f1_last_pos", 0, last_pos0, NP);
    chk("f1_latency", 0, first_vld_cyc - last_acc_cyc, 0);

    // Directed pairs for abs / saturate
    clear_got();
    a = '{2, 9, 15, 0, 5, 5, 1, 14, 8};
    b = '{9, 2, 0, 15, 5, 4, 3, 14, 1};
    drive_frame(a, b, 2*NP, 1'b0);
    wait_done();
    chk("f2_count", 1, got1.size(), NP);
    if (got1.size() == NP && got2.size() == NP && got0.size() == NP) begin
      chk("f2_abs_2_9", 1, got1[0], 7);
      chk("f2_abs_9_2", 1, got1[1], 7);
      chk("f2_sat_2_9", 2, got2[0], 0);
      chk("f2_sat_15_0", 2, got2[2], 15);
      chk("f2_sat_0_15", 2, got2[3], 0);
      chk("f2_wrap_2_9", 0, got0[0], 9);
    end

    // Random data, input gaps, out_ready toggling every cycle
    clear_got();
    foreach (a[i]) begin a[i] = $urandom_range(0, 15); b[i] = $urandom_range(0, 15); end
    toggle_en = 1'b1;
    drive_frame(a, b, 2*NP, 1'b1);
    wait_done();
    toggle_en = 1'b0;
    chk("f3_count", 0, got0.size(), NP);
    chk("f3_count", 2, got2.size(), NP);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-frame after five B pixels, then a clean frame
    foreach (a[i]) begin a[i] = 12; b[i] = 4; end
    drive_frame(a, b, NP + 5, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_ready", 0, int'(rdy[0]), 1);
    chk("rst_mid_out_valid", 0, int'(vld[0]), 0);
    @(posedge clk); #1;
    clear_got();
    foreach (a[i]) begin a[i] = 7; b[i] = 1; end
    drive_frame(a, b, 2*NP, 1'b0);
    wait_done();
    chk("f4_count", 0, got0.size(), NP);
    if (got0.size() == NP) for (int i = 0; i < NP; i++) chk("f4_wrap_6", 0, got0[i], 6);

    // Ramp frame: A=0..8, B=8..0
    clear_got();
    foreach (a[i]) begin a[i] = i; b[i] = NP - 1 - i; end
    exp5 = '{8, 6, 4, 2, 0, 2, 4, 6, 8};
    drive_frame(a, b, 2*NP, 1'b0);
    wait_done();
    chk("f5_count", 1, got1.size(), NP);
    if (got1.size() == NP) for (int i = 0; i < NP; i++) chk("f5_abs_ramp", 1, got1[i], exp5[i]);
`ifdef IMG_ABSDIFF_SUM_EN
    chk("f5_sum", 1, sum_at_last1, 40);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/img_absdiff.md
IMG_ABSDIFF -- requirements
Module: img_absdiff

Interface
REQ-001 SHALL have parameter PIX_W, default 4, pixel width in bits (legal 1..16).
REQ-002 SHALL have parameter N_PIX, default 9, pixels per image (legal 2..256).
REQ-003 SHALL have parameter MODE, default 0, result mode: 0 = wrap subtract, 1 = absolute difference, 2 = saturating subtract.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  input pixel valid.
REQ-007 SHALL have port in_image  input  PIX_W  input pixel, unsigned.
REQ-008 SHALL have port in_ready  output  1  block accepts a pixel this cycle.
REQ-009 SHALL have port out_valid  output  1  out_diff carries a result.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port out_diff  output  PIX_W  result pixel.
REQ-012 SHALL have port out_last  output  1  marks the final result of a frame.

Function
REQ-013 SHALL implement states IDLE, LOAD_A, LOAD_B, OUTPUT.
REQ-014 SHALL accept a pixel only when in_valid and in_ready are both high; in_valid gaps are allowed at any point.
REQ-015 SHALL drive in_ready high in IDLE, LOAD_A and LOAD_B, and low in OUTPUT; in_valid in OUTPUT is ignored.
REQ-016 SHALL, in IDLE, store an accepted pixel as A[0] and move to LOAD_A.
REQ-017 SHALL store accepted pixels as A[1..N_PIX-1] in LOAD_A, then move to LOAD_B on acceptance of A[N_PIX-1].
REQ-018 SHALL, on each accepted B[i] in LOAD_B, compute R[i] from A[i] and B[i], store it, and move to OUTPUT on acceptance of B[N_PIX-1].
REQ-019 SHALL compute R[i] per MODE: MODE 0 = (A-B) mod 2^PIX_W; MODE 1 = |A-B|; MODE 2 = A-B if A>=B, else 0. All operands are unsigned.
REQ-020 SHALL drive out_valid high for exactly the duration of OUTPUT; first out_valid occurs in the cycle after B[N_PIX-1] is accepted.
REQ-021 SHALL present R[0..N_PIX-1] in order; the index advances only when out_valid and out_ready are both high.
REQ-022 SHALL hold out_diff and out_last stable while out_valid is high and out_ready is low.
REQ-023 SHALL assert out_last only with R[N_PIX-1]; its acceptance returns the FSM to IDLE with in_ready high in the next cycle.
REQ-024 SHALL drive outputs from registers only, with no combinational path from in_valid, in_image or out_ready to any output.
REQ-025 SHALL drive out_diff and out_last to 0 whenever out_valid is low.
REQ-026 SHALL continue streaming from the current index after any out_ready stall, with no dropped or duplicated results.

Reset
REQ-027 SHALL, on a clk edge with rst high, enter IDLE and clear all counters, out_valid, out_diff and out_last; in any state, rst takes priority over every other input.
REQ-028 SHALL NOT require clearing of the pixel/result storage on reset; a frame in progress is discarded, and the next frame is computed only from pixels accepted after reset.
REQ-029 SHALL drive in_ready high in the first cycle after rst deasserts.

Configuration
REQ-030 SHALL, when macro IMG_ABSDIFF_SUM_EN is defined, add output port out_sum of width PIX_W+$clog2(N_PIX+1): the unsigned sum of all R[i] of the frame, valid with out_last and 0 otherwise.
REQ-031 SHALL, when IMG_ABSDIFF_SUM_EN is undefined, omit port out_sum and its accumulator; all other behaviour is unchanged.

Verification
REQ-032 SHALL cover: MODE 0, PIX_W=4, N_PIX=9, A all 3, B all 5, back-to-back, out_ready=1 -> nine results of 4'hE, out_last on the 9th, first out_valid one cycle after the 18th accept.
REQ-033 SHALL cover: MODE 1, pixel pairs (2,9) and (9,2) -> 7 for both; MODE 2, pairs (2,9) -> 0 and (15,0) -> 15.
REQ-034 SHALL cover: random in_valid gaps with out_ready toggling 1,0 each cycle -> all 9 results correct and in order, out_diff stable across every stall.
REQ-035 SHALL cover: rst pulsed after 5 B pixels -> next cycle out_valid=0 and in_ready=1; a following clean frame (A=7, B=1, MODE 0) yields nine results of 6.
REQ-036 SHALL cover, with IMG_ABSDIFF_SUM_EN defined: MODE 1, A=0..8, B=8..0 -> results 8,6,4,2,0,2,4,6,8 and out_sum=40 with out_last.
